// File: rtl/rv32imf_stream_fifo.sv
// Valid/ready stream FIFO for prefetch, load/store and FPU-result buffering.
// Supports any depth, optional fall-through and push-through-when-full.
module rv32imf_stream_fifo #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 8,
  parameter bit          FALL_THROUGH   = 1'b0,
  parameter bit          PASS_WHEN_FULL = 1'b0,
  parameter int unsigned AF_THRESH      = DEPTH - 1,
  parameter int unsigned AE_THRESH      = 1,
  localparam int unsigned CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  flush_but_first_i,
  input  logic                  clr_stats_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CNT_W-1:0]      max_cnt_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_q, rd_d;
  logic [PTR_W-1:0]      wr_q, wr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      max_q, max_d;
  logic                  empty;
  logic                  push, pop;
  logic                  bypass;
  logic                  we;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (cnt_q == '0);

  // out_ready_i reaches in_ready_o combinationally when PASS_WHEN_FULL=1.
  assign in_ready_o  = (32'(cnt_q) < DEPTH)
                     | (PASS_WHEN_FULL & out_ready_i);
  assign out_valid_o = !empty | (FALL_THROUGH & in_valid_i);
  assign out_data_o  = (FALL_THROUGH && empty) ? in_data_i
                                               : mem_q[rd_q];

  assign push   = in_valid_i & in_ready_o;
  assign pop    = out_valid_o & out_ready_i;
  assign bypass = FALL_THROUGH & empty & push & pop;
  assign we     = push & !bypass & !flush_i & !flush_but_first_i;

  assign cnt_o          = cnt_q;
  assign max_cnt_o      = max_q;
  assign almost_full_o  = (32'(cnt_q) >= AF_THRESH);
  assign almost_empty_o = (32'(cnt_q) <= AE_THRESH);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else if (flush_but_first_i) begin
      if (!empty) begin
        wr_d  = inc(rd_q);
        cnt_d = CNT_W'(1);
      end else begin
        rd_d  = '0;
        wr_d  = '0;
        cnt_d = '0;
      end
    end else if (!bypass) begin
      if (push) wr_d = inc(wr_q);
      if (pop)  rd_d = inc(rd_q);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    max_d = max_q;
    if (clr_stats_i)        max_d = cnt_q;
    else if (cnt_q > max_q) max_d = cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      max_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      max_q <= max_d;
      if (we) mem_q[wr_q] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_rv32imf_stream_fifo.sv
// Directed bench for rv32imf_stream_fifo over several parameter sets.
// All instances share inputs; each test starts from a flush.
module tb_rv32imf_stream_fifo;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fl, fbf, clr, iv, ordy;
  logic [31:0] id;

  always #5 clk_i = ~clk_i;

  logic        a_rdy, a_vld, a_af, a_ae;
  logic [31:0] a_dat;
  logic [2:0]  a_cnt, a_mx;
  logic        b_rdy, b_vld, b_af, b_ae;
  logic [31:0] b_dat;
  logic [1:0]  b_cnt, b_mx;
  logic        c_rdy, c_vld, c_af, c_ae;
  logic [31:0] c_dat;
  logic [2:0]  c_cnt, c_mx;
  logic        d_rdy, d_vld, d_af, d_ae;
  logic [31:0] d_dat;
  logic [1:0]  d_cnt, d_mx;
  logic        e_rdy, e_vld, e_af, e_ae;
  logic [31:0] e_dat;
  logic [1:0]  e_cnt, e_mx;

  rv32imf_stream_fifo #(.DEPTH(4)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(fl),
    .flush_but_first_i(fbf), .clr_stats_i(clr),
    .in_valid_i(iv), .in_ready_o(a_rdy), .in_data_i(id),
    .out_valid_o(a_vld), .out_ready_i(ordy),
    .out_data_o(a_dat), .cnt_o(a_cnt),
    .almost_full_o(a_af), .almost_empty_o(a_ae),
    .max_cnt_o(a_mx));

  rv32imf_stream_fifo #(.DEPTH(3)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(fl),
    .flush_but_first_i(fbf), .clr_stats_i(clr),
    .in_valid_i(iv), .in_ready_o(b_rdy), .in_data_i(id),
    .out_valid_o(b_vld), .out_ready_i(ordy),
    .out_data_o(b_dat), .cnt_o(b_cnt),
    .almost_full_o(b_af), .almost_empty_o(b_ae),
    .max_cnt_o(b_mx));

  rv32imf_stream_fifo #(.DEPTH(4), .FALL_THROUGH(1'b1)) u_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(fl),
    .flush_but_first_i(fbf), .clr_stats_i(clr),
    .in_valid_i(iv), .in_ready_o(c_rdy), .in_data_i(id),
    .out_valid_o(c_vld), .out_ready_i(ordy),
    .out_data_o(c_dat), .cnt_o(c_cnt),
    .almost_full_o(c_af), .almost_empty_o(c_ae),
    .max_cnt_o(c_mx));

  rv32imf_stream_fifo #(.DEPTH(2), .PASS_WHEN_FULL(1'b1)) u_d (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(fl),
    .flush_but_first_i(fbf), .clr_stats_i(clr),
    .in_valid_i(iv), .in_ready_o(d_rdy), .in_data_i(id),
    .out_valid_o(d_vld), .out_ready_i(ordy),
    .out_data_o(d_dat), .cnt_o(d_cnt),
    .almost_full_o(d_af), .almost_empty_o(d_ae),
    .max_cnt_o(d_mx));

  rv32imf_stream_fifo #(.DEPTH(2)) u_e (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(fl),
    .flush_but_first_i(fbf), .clr_stats_i(clr),
    .in_valid_i(iv), .in_ready_o(e_rdy), .in_data_i(id),
    .out_valid_o(e_vld), .out_ready_i(ordy),
    .out_data_o(e_dat), .cnt_o(e_cnt),
    .almost_full_o(e_af), .almost_empty_o(e_ae),
    .max_cnt_o(e_mx));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic flush_all();
    iv = 1'b0; ordy = 1'b0; fl = 1'b1;
    tick();
    fl = 1'b0;
  endtask

  logic [31:0] vals [4];
  logic [31:0] q [$];
  int          cnt_m, np, npop;
  logic        pu, po;

  initial begin
    vals[0] = 32'hA0; vals[1] = 32'hB1;
    vals[2] = 32'hC2; vals[3] = 32'hD3;
    rst_ni = 1'b0; fl = 1'b0; fbf = 1'b0; clr = 1'b0;
    iv = 1'b0; ordy = 1'b0; id = '0;
    #12;
    chk("rst_rdy", a_rdy, 1);
    chk("rst_vld", a_vld, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_ae", a_ae, 1);
    chk("rst_af", a_af, 0);
    chk("rst_mx", a_mx, 0);
    chk("rst_dat", a_dat, 0);
    rst_ni = 1'b1;
    tick();

    // fill 4-deep then drain
    for (int i = 0; i < 4; i++) begin
      iv = 1'b1; id = vals[i];
      tick();
      chk("t1_cnt", a_cnt, i + 1);
      chk("t1_af", a_af, (i + 1) >= 3);
      chk("t1_ae", a_ae, (i + 1) <= 1);
    end
    chk("t1_full_rdy", a_rdy, 0);
    iv = 1'b0; ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t1_vld", a_vld, 1);
      chk("t1_dat", a_dat, vals[i]);
      tick();
    end
    ordy = 1'b0;
    chk("t1_empty_vld", a_vld, 0);
    chk("t1_empty_cnt", a_cnt, 0);
    chk("t6_mx", a_mx, 4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_mx_clr", a_mx, 0);

    // depth-3 streaming with wrap
    flush_all();
    cnt_m = 0; np = 0; npop = 0; q.delete();
    for (int c = 0; c < 60 && npop < 10; c++) begin
      iv = (np < 10); id = 32'(np + 1); ordy = c[0];
      #1;
      pu = iv && (cnt_m < 3);
      po = ordy && (cnt_m > 0);
      chk("t2_rdy", b_rdy, cnt_m < 3);
      chk("t2_vld", b_vld, cnt_m > 0);
      if (po) begin
        chk("t2_dat", b_dat, q[0]);
        void'(q.pop_front());
        npop++;
      end
      if (pu) begin
        q.push_back(id);
        np++;
      end
      cnt_m = cnt_m + int'(pu) - int'(po);
      tick();
      chk("t2_cnt", b_cnt, cnt_m);
    end
    iv = 1'b0; ordy = 1'b0;
    chk("t2_done", npop, 10);

    // fall-through on empty
    flush_all();
    iv = 1'b1; id = 32'h55; ordy = 1'b1;
    #1;
    chk("t3_vld", c_vld, 1);
    chk("t3_dat", c_dat, 32'h55);
    tick();
    iv = 1'b0; ordy = 1'b0;
    chk("t3_cnt0", c_cnt, 0);
    iv = 1'b1;
    tick();
    iv = 1'b0;
    chk("t3_cnt1", c_cnt, 1);
    chk("t3_head", c_dat, 32'h55);

    // push-through when full vs not
    flush_all();
    iv = 1'b1; id = 32'h58;
    tick();
    id = 32'h59;
    tick();
    id = 32'h5A; ordy = 1'b1;
    #1;
    chk("t4_d_rdy", d_rdy, 1);
    chk("t4_e_rdy", e_rdy, 0);
    chk("t4_d_dat", d_dat, 32'h58);
    tick();
    iv = 1'b0;
    chk("t4_d_cnt", d_cnt, 2);
    chk("t4_e_cnt", e_cnt, 1);
    chk("t4_d_y", d_dat, 32'h59);
    chk("t4_e_y", e_dat, 32'h59);
    tick();
    chk("t4_d_z", d_dat, 32'h5A);
    chk("t4_d_cnt1", d_cnt, 1);
    tick();
    ordy = 1'b0;
    chk("t4_d_cnt0", d_cnt, 0);

    // flush_but_first with concurrent handshakes
    flush_all();
    iv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id = 32'h11 * (i + 1);
      tick();
    end
    chk("t5_cnt3", a_cnt, 3);
    fbf = 1'b1; id = 32'h44; ordy = 1'b1;
    tick();
    fbf = 1'b0; ordy = 1'b0;
    chk("t5_cnt1", a_cnt, 1);
    chk("t5_head", a_dat, 32'h11);
    id = 32'h66;
    tick();
    iv = 1'b0; ordy = 1'b1;
    chk("t5_cnt2", a_cnt, 2);
    tick();
    chk("t5_next", a_dat, 32'h66);
    ordy = 1'b0;
    fl = 1'b1; fbf = 1'b1;
    tick();
    fl = 1'b0; fbf = 1'b0;
    chk("t5_fl_cnt", a_cnt, 0);
    chk("t5_fl_vld", a_vld, 0);

    // async reset mid-stream
    iv = 1'b1; id = 32'h77;
    tick();
    tick();
    iv = 1'b0;
    chk("t6_pre", a_cnt, 2);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("t6_cnt", a_cnt, 0);
    chk("t6_vld", a_vld, 0);
    chk("t6_rdy", a_rdy, 1);
    chk("t6_dat", a_dat, 0);
    chk("t6_mx0", a_mx, 0);
    chk("t6_ae", a_ae, 1);
    rst_ni = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
